usb_boot_sequencer: RTL and testbench

// - Sequences the bootloader's hand-off from USB/SPI-flash service to the user design.
// - Watches host SOF activity and warm-boot requests from the USB-SPI bridge endpoint.
// - Fences further SPI bridge transactions, waits for the flash bus to go idle, then raises boot.
// - Sits between usb_fs_pe (sof_valid), usb_spi_bridge_ep (boot request, spi_cs_b) and the FPGA warm-boot primitive.

---
 rtl/usb_boot_seq_pkg.sv | 18 +
 rtl/usb_boot_sequencer_if.sv | 50 +++++
 rtl/boot_seq_idle_timer.sv | 41 ++++
 rtl/usb_boot_sequencer.sv | 116 +++++++++++
 tb/tb_usb_boot_sequencer.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/usb_boot_seq_pkg.sv
// rtl/usb_boot_seq_pkg.sv - shared state encodings and defaults for the USB boot sequencer
//
// Purpose : state enum for the boot hand-off FSM and the default warm-boot image.
// Ports   : none (package).
package usb_boot_seq_pkg;

  // Encodings are visible on seq_state for debug/LED mode, so keep them fixed.
  typedef enum logic [1:0] {
    WAIT_HOST   = 2'd0,
    HOST_ACTIVE = 2'd1,
    DRAIN       = 2'd2,
    BOOT        = 2'd3
  } seq_state_e;

  // Image used when the hand-off is caused by host timeout rather than a request.
  localparam logic [1:0] DEFAULT_BOOT_IMAGE = 2'd0;

endpackage

// File: rtl/usb_boot_sequencer_if.sv
// rtl/usb_boot_sequencer_if.sv - signal bundle between the boot sequencer and its neighbours
//
// Purpose : groups the SOF/boot-request/SPI inputs and boot outputs of usb_boot_sequencer.
// Ports   : none; modport slave is the sequencer, modport master is the environment.
//   sof_valid      : one-cycle pulse per received SOF token
//   boot_req       : one-cycle warm-boot request from the SPI bridge endpoint
//   boot_image_sel : image index, sampled with boot_req
//   spi_cs_b       : flash chip-select from the bridge (1 = idle)
//   spi_bridge_en  : 1 = bridge may start new SPI transactions
//   host_seen      : sticky, at least one SOF since reset
//   boot           : warm-boot trigger, terminal once set
//   boot_image     : image index, stable while boot=1
//   seq_state      : current FSM state encoding
interface usb_boot_sequencer_if;

  logic       sof_valid;
  logic       boot_req;
  logic [1:0] boot_image_sel;
  logic       spi_cs_b;
  logic       spi_bridge_en;
  logic       host_seen;
  logic       boot;
  logic [1:0] boot_image;
  logic [1:0] seq_state;

  modport master (
    output sof_valid,
    output boot_req,
    output boot_image_sel,
    output spi_cs_b,
    input  spi_bridge_en,
    input  host_seen,
    input  boot,
    input  boot_image,
    input  seq_state
  );

  modport slave (
    input  sof_valid,
    input  boot_req,
    input  boot_image_sel,
    input  spi_cs_b,
    output spi_bridge_en,
    output host_seen,
    output boot,
    output boot_image,
    output seq_state
  );

endinterface

// File: rtl/boot_seq_idle_timer.sv
// rtl/boot_seq_idle_timer.sv - saturating cycle counter with clear, enable and LIMIT-1 hit
//
// Purpose : counts enabled cycles since the last clear; saturates at LIMIT, never wraps.
// Ports   :
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   i_clr   : synchronous clear (wins over enable)
//   i_en    : count enable
//   o_hit   : combinational, high in the cycle the count will reach LIMIT
module boot_seq_idle_timer
  import usb_boot_seq_pkg::*;
#(
  parameter int unsigned LIMIT = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_hit
);

  localparam int unsigned W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LIMIT_VAL = W'(LIMIT);
  localparam logic [W-1:0] HIT_VAL   = W'(LIMIT - 1);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != LIMIT_VAL)) begin
      r_count <= r_count + W'(1);
    end
  end

  // Fires once per run: after saturation the count sits at LIMIT, not LIMIT-1.
  assign o_hit = i_en && !i_clr && (r_count == HIT_VAL);

endmodule

// File: rtl/usb_boot_sequencer.sv
// rtl/usb_boot_sequencer.sv - bootloader hand-off sequencer from USB/SPI service to user image
//
// Purpose : watches SOF activity and warm-boot requests, fences the SPI bridge, waits for
//           the flash bus to stay idle, then raises boot with the latched image index.
// Ports   :
//   clk     : system clock, all logic on posedge
//   reset_n : asynchronous active-low reset
//   bus     : usb_boot_sequencer_if.slave (sof_valid, boot_req, boot_image_sel, spi_cs_b in;
//             spi_bridge_en, host_seen, boot, boot_image, seq_state out)
module usb_boot_sequencer
  import usb_boot_seq_pkg::*;
#(
  parameter int unsigned HOST_TIMEOUT_CYCLES = 48000000,
  parameter int unsigned GUARD_CYCLES        = 1024,
  parameter logic [1:0]  DEFAULT_IMAGE       = DEFAULT_BOOT_IMAGE
) (
  input  logic                 clk,
  input  logic                 reset_n,
  usb_boot_sequencer_if.slave  bus
);

  generate
    if (GUARD_CYCLES < 1) begin : g_bad_guard
      $error("GUARD_CYCLES must be at least 1");
    end
    if (HOST_TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("HOST_TIMEOUT_CYCLES must be at least 2");
    end
  endgenerate

  seq_state_e r_state;
  logic       r_bridge_en;
  logic       r_host_seen;
  logic       r_boot;
  logic [1:0] r_image;

  logic w_timeout_hit;
  logic w_guard_en;
  logic w_guard_clr;
  logic w_guard_hit;

  // SOF idle time: every SOF restarts the count, otherwise it free-runs to saturation.
  boot_seq_idle_timer #(
    .LIMIT (HOST_TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clr   (bus.sof_valid),
    .i_en    (1'b1),
    .o_hit   (w_timeout_hit)
  );

  // Guard time only accumulates inside DRAIN; held at zero elsewhere so DRAIN
  // always starts from a clean count.
  assign w_guard_en  = (r_state == DRAIN) && bus.spi_cs_b;
  assign w_guard_clr = (r_state != DRAIN) || !bus.spi_cs_b;

  boot_seq_idle_timer #(
    .LIMIT (GUARD_CYCLES)
  ) u_guard_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clr   (w_guard_clr),
    .i_en    (w_guard_en),
    .o_hit   (w_guard_hit)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= WAIT_HOST;
      r_bridge_en <= 1'b1;
      r_host_seen <= 1'b0;
      r_boot      <= 1'b0;
      r_image     <= DEFAULT_IMAGE;
    end else begin
      r_host_seen <= r_host_seen | bus.sof_valid;
      // Outputs follow the current state, so they lag a state change by one cycle.
      r_bridge_en <= (r_state == WAIT_HOST) || (r_state == HOST_ACTIVE);
      r_boot      <= (r_state == BOOT);

      case (r_state)
        WAIT_HOST, HOST_ACTIVE: begin
          // boot_req beats SOF and timeout; SOF beats timeout (timeout_hit
          // already excludes an SOF cycle).
          if (bus.boot_req) begin
            r_image <= bus.boot_image_sel;
            r_state <= DRAIN;
          end else if (bus.sof_valid) begin
            r_state <= HOST_ACTIVE;
          end else if (w_timeout_hit) begin
            r_image <= DEFAULT_IMAGE;
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_guard_hit) begin
            r_state <= BOOT;
          end
        end
        BOOT: begin
          r_state <= BOOT;
        end
        default: begin
          r_state <= WAIT_HOST;
        end
      endcase
    end
  end

  assign bus.spi_bridge_en = r_bridge_en;
  assign bus.host_seen     = r_host_seen;
  assign bus.boot          = r_boot;
  assign bus.boot_image    = r_image;
  assign bus.seq_state     = r_state;

endmodule

// File: tb/tb_usb_boot_sequencer.sv
// tb/tb_usb_boot_sequencer.sv - self-checking bench for usb_boot_sequencer
//
// Purpose : table of boot scenarios with expected drain/boot cycles and image, a scoreboard
//           of expected boot events, plus hand sequences for reset behaviour.
// Ports   : none (top-level bench).
module tb_usb_boot_sequencer;

  localparam int unsigned T_HOST  = 100;
  localparam int unsigned T_GUARD = 8;

  logic clk;
  logic reset_n;

  usb_boot_sequencer_if bif ();

  usb_boot_sequencer #(
    .HOST_TIMEOUT_CYCLES (T_HOST),
    .GUARD_CYCLES        (T_GUARD),
    .DEFAULT_IMAGE       (2'd0)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         req_at;
    logic [1:0] sel;
    int         sof_at;
    int         sof_period;
    int         sof_until;
    int         cs_lo_start;
    int         cs_lo_end;
    int         exp_drain;
    int         exp_boot;
    logic [1:0] exp_image;
    logic       exp_host;
    int         chk_cyc;
    logic [1:0] chk_state;
  } vec_t;

  typedef struct {
    int         cyc;
    logic [1:0] img;
  } sb_t;

  sb_t  sb_q[$];
  vec_t vecs[11];
  int   checks;
  int   errors;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    bif.sof_valid      = 1'b0;
    bif.boot_req       = 1'b0;
    bif.boot_image_sel = 2'd0;
    bif.spi_cs_b       = 1'b1;
    reset_n            = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Cycle c = number of rising edges since reset release; sampled and driven on negedge.
  task automatic run_vec(input int idx, input vec_t v);
    bit  seen;
    int  post;
    sb_t e;
    seen = 1'b0;
    post = 0;
    apply_reset();
    sb_q.push_back('{cyc: v.exp_boot, img: v.exp_image});
    for (int c = 0; c < v.exp_boot + 50; c++) begin
      if (c == v.chk_cyc)
        check($sformatf("v%0d state@%0d", idx, c), 32'(bif.seq_state), 32'(v.chk_state));
      if (c == v.exp_drain) begin
        check($sformatf("v%0d drain_state@%0d", idx, c), 32'(bif.seq_state), 32'd2);
        check($sformatf("v%0d en_at_drain", idx), 32'(bif.spi_bridge_en), 32'd1);
        check($sformatf("v%0d host_seen", idx), 32'(bif.host_seen), 32'(v.exp_host));
      end
      if (c == v.exp_drain + 1)
        check($sformatf("v%0d en_after_drain", idx), 32'(bif.spi_bridge_en), 32'd0);
      if (seen) begin
        post++;
        check($sformatf("v%0d post_boot", idx), 32'(bif.boot), 32'd1);
        check($sformatf("v%0d post_image", idx), 32'(bif.boot_image), 32'(v.exp_image));
        check($sformatf("v%0d post_state", idx), 32'(bif.seq_state), 32'd3);
        if (post >= 3) break;
      end else if (bif.boot === 1'b1) begin
        seen = 1'b1;
        e = sb_q.pop_front();
        check($sformatf("v%0d boot_cycle", idx), 32'(c), 32'(e.cyc));
        check($sformatf("v%0d boot_image", idx), 32'(bif.boot_image), 32'(e.img));
      end
      if (seen) begin
        // Late requests and SOFs must not disturb a completed hand-off.
        bif.boot_req       = 1'b1;
        bif.boot_image_sel = ~v.exp_image;
        bif.sof_valid      = 1'b1;
        bif.spi_cs_b       = 1'b0;
      end else begin
        bif.boot_req       = (c == v.req_at);
        bif.boot_image_sel = (c == v.req_at) ? v.sel : 2'($urandom_range(3, 0));
        bif.sof_valid      = (c == v.sof_at) ||
                             ((v.sof_period != 0) && (c % v.sof_period == 0) && (c < v.sof_until));
        bif.spi_cs_b       = !((c >= v.cs_lo_start) && (c < v.cs_lo_end));
      end
      @(negedge clk);
    end
    if (!seen) begin
      errors++;
      checks++;
      $display("FAIL v%0d boot_timeout: got boot=%0d expected boot=1 by cycle %0d",
               idx, bif.boot, v.exp_boot);
      void'(sb_q.pop_front());
    end
    bif.boot_req  = 1'b0;
    bif.sof_valid = 1'b0;
    bif.spi_cs_b  = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    //            req  sel  sof  per  until lo_s lo_e drain boot img host chk  st
    vecs[0]  = '{-1,  2'd0, -1,  0,   0,    0,   0,   100,  109, 2'd0, 1'b0, 99,  2'd0};
    vecs[1]  = '{10,  2'd2, -1,  0,   0,    0,   31,  11,   40,  2'd2, 1'b0, 10,  2'd0};
    vecs[2]  = '{5,   2'd1, -1,  0,   0,    0,   0,   6,    15,  2'd1, 1'b0, 5,   2'd0};
    vecs[3]  = '{99,  2'd3, -1,  0,   0,    0,   0,   100,  109, 2'd3, 1'b0, 99,  2'd0};
    vecs[4]  = '{0,   2'd3, -1,  0,   0,    5,   6,   1,    15,  2'd3, 1'b0, 0,   2'd0};
    vecs[5]  = '{20,  2'd1, -1,  0,   0,    27,  28,  21,   37,  2'd1, 1'b0, 20,  2'd0};
    vecs[6]  = '{-1,  2'd0, -1,  0,   0,    100, 120, 100,  129, 2'd0, 1'b0, 99,  2'd0};
    vecs[7]  = '{-1,  2'd0, -1,  50,  1000, 0,   0,   1051, 1060, 2'd0, 1'b1, 999, 2'd1};
    vecs[8]  = '{-1,  2'd0, 99,  0,   0,    0,   0,   200,  209, 2'd0, 1'b1, 100, 2'd1};
    vecs[9]  = '{30,  2'd2, 30,  0,   0,    0,   0,   31,   40,  2'd2, 1'b1, 30,  2'd0};
    vecs[10] = '{3,   2'd1, -1,  0,   0,    0,   0,   4,    13,  2'd1, 1'b0, 3,   2'd0};

    // Reset values, observed while reset is still held.
    bif.sof_valid      = 1'b0;
    bif.boot_req       = 1'b0;
    bif.boot_image_sel = 2'd0;
    bif.spi_cs_b       = 1'b1;
    reset_n            = 1'b0;
    repeat (2) @(negedge clk);
    check("rst state",     32'(bif.seq_state),     32'd0);
    check("rst bridge_en", 32'(bif.spi_bridge_en), 32'd1);
    check("rst host_seen", 32'(bif.host_seen),     32'd0);
    check("rst boot",      32'(bif.boot),          32'd0);
    check("rst image",     32'(bif.boot_image),    32'd0);

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // Asynchronous reset from BOOT (vector 9 left boot=1, host_seen=1, image=2).
    check("pre_rst boot", 32'(bif.boot), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("async boot",      32'(bif.boot),          32'd0);
    check("async bridge_en", 32'(bif.spi_bridge_en), 32'd1);
    check("async state",     32'(bif.seq_state),     32'd0);
    check("async host_seen", 32'(bif.host_seen),     32'd0);
    check("async image",     32'(bif.boot_image),    32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    run_vec(10, vecs[10]);

    check("scoreboard empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
